// File: rtl/pwm_duty_meter.sv
// Measures period, high time and duty cycle of an asynchronous pulse train.
// A restoring divider turns {high, period} into an integer percentage.
module pwm_duty_meter #(
  parameter int CNT_W          = 28,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             Clk_50M,
  input  logic             Rst_n,
  input  logic             Sw,
  input  logic             Pwm_in,
  output logic [CNT_W-1:0] Period_cnt,
  output logic [CNT_W-1:0] High_cnt,
  output logic [6:0]       Duty_pct,
  output logic             Valid,
  output logic             Timeout,
  output logic             Overrun
);
  localparam int NUM_W = CNT_W + 7;
  localparam int STP_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nxt;

  logic [2:0] sync_q;
  logic       pwm_s, rise, fall;

  assign pwm_s = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], Pwm_in};

  logic [CNT_W-1:0] cnt, hi_meas;
  logic             cnt_restart, tmo, tmo_hit, capture_hi, launch, busy, done;

  // >= rather than == so a fall landing on the limit still times out next cycle
  assign tmo_hit = (cnt >= TO_LIM);

  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    tmo         = 1'b0;
    capture_hi  = 1'b0;
    launch      = 1'b0;
    Overrun     = 1'b0;
    if (!Sw) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (rise) begin
                state_nxt   = HIGH;
                cnt_restart = 1'b1;
              end else if (tmo_hit) tmo = 1'b1;
        HIGH: if (fall) begin
                state_nxt  = LOW;
                capture_hi = 1'b1;
              end else if (tmo_hit) begin
                state_nxt = IDLE;
                tmo       = 1'b1;
              end
        LOW:  if (rise) begin
                state_nxt   = HIGH;
                cnt_restart = 1'b1;
                Overrun     = busy;
                launch      = ~busy;
              end else if (tmo_hit) begin
                state_nxt = IDLE;
                tmo       = 1'b1;
              end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Counter reads 1 in the cycle after an edge, so it holds N at the edge N cycles later.
  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n)           cnt <= '0;
    else if (!Sw)         cnt <= '0;
    else if (cnt_restart) cnt <= CNT_W'(1);
    else if (tmo)         cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);

  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n)          hi_meas <= '0;
    else if (capture_hi) hi_meas <= cnt;

  logic [NUM_W-1:0] num_q;
  logic [CNT_W-1:0] den_q, div_hi, rem_q, rem_nx;
  logic [CNT_W:0]   rem_sh, den_ext;
  logic [5:0]       quo_q;
  logic [6:0]       quo_nx;
  logic [STP_W-1:0] step_q;
  logic             q_bit;

  assign busy    = (step_q != '0);
  assign done    = (step_q == STP_W'(1));
  assign rem_sh  = {rem_q, num_q[NUM_W-1]};
  assign den_ext = {1'b0, den_q};
  assign q_bit   = (rem_sh >= den_ext);
  assign rem_nx  = q_bit ? CNT_W'(rem_sh - den_ext) : rem_sh[CNT_W-1:0];
  // Quotient never exceeds 100, so every partial quotient before the last fits in 6 bits.
  assign quo_nx  = {quo_q, q_bit};

  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n) begin
      num_q  <= '0;
      den_q  <= '0;
      div_hi <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
    end else if (!Sw) begin
      step_q <= '0;
    end else if (launch) begin
      num_q  <= NUM_W'(hi_meas) * NUM_W'(100);
      den_q  <= cnt;
      div_hi <= hi_meas;
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= STP_W'(NUM_W);
    end else if (busy) begin
      num_q  <= {num_q[NUM_W-2:0], 1'b0};
      rem_q  <= rem_nx;
      quo_q  <= quo_nx[5:0];
      step_q <= step_q - STP_W'(1);
    end

  always_ff @(posedge Clk_50M or negedge Rst_n)
    if (!Rst_n) begin
      Period_cnt <= '0;
      High_cnt   <= '0;
      Duty_pct   <= '0;
      Valid      <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (Sw) begin
        if (done) begin
          Period_cnt <= den_q;
          High_cnt   <= div_hi;
          Duty_pct   <= quo_nx;
          Valid      <= 1'b1;
          Timeout    <= 1'b0;
        end else if (tmo) begin
          Period_cnt <= '0;
          High_cnt   <= '0;
          Duty_pct   <= pwm_s ? 7'd100 : 7'd0;
          Timeout    <= 1'b1;
        end
      end
    end
endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter: CNT_W, default 28, width of the cycle counters and the period/high outputs.
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000000 (1 s at 50 MHz), number of edge-free cycles before timeout; must be less than 2^CNT_W.
REQ-003 Clk_50M  input  1  sole clock, 50 MHz, all flops rising-edge.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 Sw  input  1  measurement enable, synchronous to Clk_50M.
REQ-006 Pwm_in  input  1  asynchronous pulse train under measurement (e.g. a blinking LED drive).
REQ-007 Period_cnt  output  CNT_W  Clk_50M cycles between consecutive rising edges.
REQ-008 High_cnt  output  CNT_W  Clk_50M cycles from a rising edge to the following falling edge.
REQ-009 Duty_pct  output  7  floor(High_cnt*100/Period_cnt), range 0..100.
REQ-010 Valid  output  1  one-cycle pulse when the three result outputs update from a new measurement.
REQ-011 Timeout  output  1  level; no Pwm_in edge seen for TIMEOUT_CYCLES.
REQ-012 Overrun  output  1  one-cycle pulse when a completed period is discarded.

Function
REQ-013 Pwm_in SHALL pass through a 2-flop synchronizer; edges are detected on the synchronized signal, with detection in the cycle the synchronized value changes.
REQ-014 FSM states SHALL be IDLE, HIGH, LOW.
REQ-015 IDLE: a rising edge SHALL reset the cycle counter and enter HIGH; a falling edge SHALL be ignored; no result is produced.
REQ-016 HIGH: a falling edge SHALL capture the counter value as the high count and enter LOW.
REQ-017 LOW: a rising edge SHALL capture the counter value as the period, hand {high, period} to the divider, reset the counter, and re-enter HIGH.
REQ-018 The counter SHALL count cycles so that a signal with rising edges N cycles apart yields period N, and a high phase of H cycles yields high count H.
REQ-019 The divider SHALL be sequential (one quotient bit per cycle) and compute floor(high*100/period) with a 35-bit numerator.
REQ-020 Period_cnt, High_cnt, Duty_pct SHALL update, and Valid SHALL pulse, exactly 36 cycles after the closing rising-edge detection cycle (edge cycle = 0).
REQ-021 Counting of the next period SHALL continue while the divider is busy.
REQ-022 If a closing rising edge occurs while the divider is busy, that measurement SHALL be discarded, Overrun SHALL pulse in that cycle, the in-flight result SHALL complete normally, and the FSM SHALL continue in HIGH.
REQ-023 If the counter reaches TIMEOUT_CYCLES in any non-IDLE state without an edge, the FSM SHALL enter IDLE; Timeout SHALL assert; Period_cnt and High_cnt SHALL become 0; Duty_pct SHALL become 100 if synchronized Pwm_in is high, else 0; Valid SHALL NOT pulse.
REQ-024 In IDLE, the same timeout rule SHALL apply from reset release or from the last timeout, so a constant input still reports Timeout.
REQ-025 Timeout SHALL clear only in the cycle Valid next pulses.
REQ-026 The counter SHALL never wrap; the timeout bound guarantees this.
REQ-027 Sw low SHALL force IDLE, clear the counter, abort any division without a Valid pulse, and hold all result outputs and Timeout; the first period after Sw rises SHALL NOT be reported.

Reset
REQ-028 Rst_n low SHALL immediately force IDLE, clear the synchronizer, counter and divider, and drive Period_cnt=0, High_cnt=0, Duty_pct=0, Valid=0, Timeout=0, Overrun=0.
REQ-029 After release, the first rising edge SHALL only open a measurement; the first Valid SHALL follow the second rising edge.

Verification (TIMEOUT_CYCLES=1000 in simulation)
REQ-030 Reset asserted mid-HIGH -> all outputs 0 in the same cycle; no Valid until two rising edges after release.
REQ-031 Period 200, high 20, repeated -> Valid once per period starting 36 cycles after the 2nd rising edge; Period_cnt=200, High_cnt=20, Duty_pct=10.
REQ-032 Period 100, high 50, then switched to period 300, high 299 -> Duty_pct 50, then 99 with Period_cnt=300.
REQ-033 Input held high for 1200 cycles after a valid measurement -> Timeout=1, Duty_pct=100, counts 0; resume period 200/high 100 -> Timeout clears with the first Valid, Duty_pct=50.
REQ-034 Period 30, high 15 -> alternate rising edges produce Overrun pulses, reported measurements show Period_cnt=30, Duty_pct=50, and there are no Valid pulses for the dropped periods.
REQ-035 Sw dropped during a division -> no Valid, outputs held; Sw raised -> first report after the second rising edge.
